// File: rtl/alu_pkg.sv
// alu_pkg: state encoding and default widths shared by sq_accum and the sqrt unit
package alu_pkg;

    localparam int SQ_DATA_LEN = 16;
    localparam int SQ_OUT_LEN  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } sq_state_t;

endpackage

// File: rtl/sq_mul.sv
// sq_mul: registered signed squarer, one-cycle latency, result is an unsigned 2*dataLen-bit square
module sq_mul
    import alu_pkg::*;
#(
    parameter int dataLen = SQ_DATA_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [dataLen-1:0]     din,
    output logic [2*dataLen-1:0]   prod,
    output logic                   prod_v
);

    logic signed [2*dataLen-1:0] d;
    logic signed [2*dataLen-1:0] sq;

    // Sign-extend first so the multiply is done at full product width
    assign d  = {{dataLen{din[dataLen-1]}}, din};
    assign sq = d * d;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod   <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_v <= en;
            if (en) prod <= sq;
        end
    end

endmodule

// File: rtl/sq_accum.sv
// sq_accum: streaming sum-of-squares accumulator feeding the sqrt unit.
// Define SQ_ACCUM_SAT_EN to clamp the sum on overflow instead of wrapping.
module sq_accum
    import alu_pkg::*;
#(
    parameter int dataLen = SQ_DATA_LEN,
    parameter int outLen  = SQ_OUT_LEN,
    parameter int cntLen  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cntLen-1:0]  vec_len,
    input  logic               in_valid,
    input  logic [dataLen-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [outLen-1:0]  out_data,
    output logic               overflow,
    output logic               busy
);

    sq_state_t state, state_nxt;
    logic [cntLen-1:0]    cnt;
    logic [outLen-1:0]    acc;
    logic [outLen-1:0]    acc_nxt;
    logic [outLen:0]      sum;
    logic [2*dataLen-1:0] prod;
    logic                 prod_v;
    logic                 ovf;
    logic                 accept;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;
    assign out_data  = acc;
    assign overflow  = ovf;
    assign accept    = in_valid && in_ready;

    sq_mul #(.dataLen(dataLen)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .en     (accept),
        .din    (in_data),
        .prod   (prod),
        .prod_v (prod_v)
    );

    // One extra bit so the carry-out of each addition is visible
    assign sum = {1'b0, acc} + {{(outLen + 1 - 2 * dataLen){1'b0}}, prod};

`ifdef SQ_ACCUM_SAT_EN
    assign acc_nxt = sum[outLen] ? {outLen{1'b1}} : sum[outLen-1:0];
`else
    assign acc_nxt = sum[outLen-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (vec_len == '0) ? OUT : ACCUM;
            ACCUM:   if (accept && cnt == cntLen'(1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            default: if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                acc <= '0;
                ovf <= 1'b0;
                cnt <= vec_len;
            end else if (prod_v) begin
                acc <= acc_nxt;
                ovf <= ovf | sum[outLen];
            end
            if (accept) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_sq_accum.sv
// tb_sq_accum: directed self-checking bench for sq_accum
module tb_sq_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  vec_len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        overflow;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SQ_ACCUM_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    sq_accum dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic begin_vec(input logic [9:0] n);
        start = 1'b1;
        vec_len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        vec_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        begin_vec(10'd2);
        n_chk++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accum busy=%b in_ready=%b want 1 1", busy, in_ready); end
        send(16'd3);
        send(-16'sd4);
        n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'd25) begin n_fail++; $display("FAIL basic_sum got %0d want 25", out_data); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got %b want 0", overflow); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle busy=%b out_valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_zero_len;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'd7;
        begin_vec(10'd0);
        n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_out out_valid=%b in_ready=%b want 1 0", out_valid, in_ready); end
        @(negedge clk);
        n_chk++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL zero_data got %0d want 0", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle busy got %b want 0", busy); end
    endtask

    task automatic test_overflow;
        bit ok;
        out_ready = 1'b1;
        begin_vec(10'd4);
        in_valid = 1'b1;
        in_data = 16'h8000;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_out(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout out_valid got 0 want 1"); end
        n_chk++; if (out_data !== OVF_EXP) begin n_fail++; $display("FAIL ovf_data got %h want %h", out_data, OVF_EXP); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        @(negedge clk);
    endtask

    task automatic test_gaps_backpressure;
        bit ok;
        out_ready = 1'b0;
        begin_vec(10'd3);
        send(16'd1);
        @(negedge clk);
        send(16'd2);
        @(negedge clk);
        send(16'd3);
        wait_out(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL gaps_timeout out_valid got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (out_valid !== 1'b1 || out_data !== 32'd14) begin n_fail++; $display("FAIL gaps_hold%0d out_valid=%b data=%0d want 1 14", i, out_valid, out_data); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_release out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        begin_vec(10'd4);
        send(16'd10);
        send(16'd20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++; if (busy !== 1'b0 || out_data !== 32'd0) begin n_fail++; $display("FAIL mid_reset busy=%b data=%0d want 0 0", busy, out_data); end
        begin_vec(10'd1);
        send(16'd5);
        wait_out(ok);
        n_chk++; if (!ok || out_data !== 32'd25) begin n_fail++; $display("FAIL mid_new ok=%b data=%0d want 1 25", ok, out_data); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        bit ok;
        out_ready = 1'b0;
        begin_vec(10'd2);
        send(16'd6);
        start = 1'b1;
        vec_len = 10'd1;
        @(negedge clk);
        start = 1'b0;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ign_accum in_ready got %b want 1", in_ready); end
        send(16'd8);
        in_valid = 1'b1;
        in_data = 16'd100;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(ok);
        n_chk++; if (!ok || out_data !== 32'd100) begin n_fail++; $display("FAIL ign_drain ok=%b data=%0d want 1 100", ok, out_data); end
        start = 1'b1;
        vec_len = 10'd0;
        @(negedge clk);
        start = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_data !== 32'd100) begin n_fail++; $display("FAIL ign_out out_valid=%b data=%0d want 1 100", out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle busy got %b want 0", busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_zero_len;
        test_overflow;
        test_gaps_backpressure;
        test_reset_mid;
        test_ignore_start;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
